// File: rtl/branch_predictor_table.sv
// Table of saturating up/down direction counters with optional gshare hashing
// and a saturating mispredict counter. One lookup and one update per cycle.
module branch_predictor_table #(
    parameter int unsigned CTR_WIDTH  = 2,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned HIST_BITS  = 0,
    parameter int unsigned RESET_CTR  = 0,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                                       Clk,
    input  logic                                       reset,
    input  logic                                       PredValid,
    input  logic [INDEX_BITS-1:0]                      PredIndex,
    output logic                                       PredOutValid,
    output logic                                       PredTaken,
    output logic                                       PredStrong,
    output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] PredHistory,
    input  logic                                       UpdValid,
    input  logic [INDEX_BITS-1:0]                      UpdIndex,
    input  logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] UpdHistory,
    input  logic                                       UpdTaken,
    input  logic                                       UpdPredTaken,
    output logic [STAT_WIDTH-1:0]                      MissCount
);

    localparam int unsigned HW    = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam int unsigned DEPTH = 2 ** INDEX_BITS;

    localparam logic [CTR_WIDTH-1:0] CTR_MAX    = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_RST    = CTR_WIDTH'(RESET_CTR);
    localparam logic                 RST_TAKEN  = CTR_RST[CTR_WIDTH-1];
    localparam logic                 RST_STRONG = (CTR_RST == '0) || (CTR_RST == CTR_MAX);

    logic [CTR_WIDTH-1:0]  ctr_q [DEPTH];
    logic [CTR_WIDTH-1:0]  ctr_d [DEPTH];
    logic [HW-1:0]         ghr_q, ghr_d;
    logic [STAT_WIDTH-1:0] miss_q, miss_d;
    logic                  pred_out_valid_q, pred_out_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic                  pred_strong_q, pred_strong_d;
    logic [HW-1:0]         pred_history_q, pred_history_d;

    logic [INDEX_BITS-1:0] ghr_ext, upd_hist_ext;
    logic [INDEX_BITS-1:0] pred_idx, upd_idx;
    logic [CTR_WIDTH-1:0]  upd_cur, upd_nxt, pred_ctr;

    always_comb begin
        ghr_ext      = '0;
        upd_hist_ext = '0;
        if (HIST_BITS > 0) begin
            ghr_ext      = INDEX_BITS'(ghr_q);
            upd_hist_ext = INDEX_BITS'(UpdHistory);
        end
        pred_idx = PredIndex ^ ghr_ext;
        upd_idx  = UpdIndex ^ upd_hist_ext;

        ctr_d   = ctr_q;
        upd_cur = ctr_q[upd_idx];
        upd_nxt = upd_cur;
        if (UpdValid) begin
            if (UpdTaken && (upd_cur != CTR_MAX)) begin
                upd_nxt = upd_cur + 1'b1;
            end else if (!UpdTaken && (upd_cur != '0)) begin
                upd_nxt = upd_cur - 1'b1;
            end
            ctr_d[upd_idx] = upd_nxt;
        end
        // Reading the post-update table gives write-first bypass on index collision.
        pred_ctr = ctr_d[pred_idx];

        ghr_d = ghr_q;
        if ((HIST_BITS > 0) && UpdValid) begin
            ghr_d = HW'({ghr_q, UpdTaken});
        end

        miss_d = miss_q;
        if (UpdValid && (UpdTaken != UpdPredTaken) && (miss_q != '1)) begin
            miss_d = miss_q + 1'b1;
        end

        pred_out_valid_d = PredValid;
        pred_taken_d     = pred_taken_q;
        pred_strong_d    = pred_strong_q;
        pred_history_d   = pred_history_q;
        if (PredValid) begin
            pred_taken_d   = pred_ctr[CTR_WIDTH-1];
            pred_strong_d  = (pred_ctr == '0) || (pred_ctr == CTR_MAX);
            pred_history_d = ghr_q;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_RST;
            end
            ghr_q            <= '0;
            miss_q           <= '0;
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= RST_TAKEN;
            pred_strong_q    <= RST_STRONG;
            pred_history_q   <= '0;
        end else begin
            ctr_q            <= ctr_d;
            ghr_q            <= ghr_d;
            miss_q           <= miss_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_strong_q    <= pred_strong_d;
            pred_history_q   <= pred_history_d;
        end
    end

    assign PredOutValid = pred_out_valid_q;
    assign PredTaken    = pred_taken_q;
    assign PredStrong   = pred_strong_q;
    assign PredHistory  = pred_history_q;
    assign MissCount    = miss_q;

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised branch-direction predictor: a table of 2^INDEX_BITS saturating up/down counters of CTR_WIDTH bits each.
- Optional global-history (gshare) index hashing and a saturating mispredict statistics counter.
- Sits beside the fetch stage: fetch issues predict lookups, execute/retire issues outcome updates.
- Generalises the single 2-bit Taken/Strong counter to N entries, W-bit counters, history hashing and statistics.

Parameters:
- CTR_WIDTH, 2, bits per saturating counter (>=2).
- INDEX_BITS, 4, table index width; table depth = 2^INDEX_BITS.
- HIST_BITS, 0, global history length; 0 = bimodal (no hashing); must be <= INDEX_BITS.
- RESET_CTR, 0, counter value loaded into every entry on reset (0 = strongly not-taken).
- STAT_WIDTH, 16, width of the mispredict counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- PredValid  in  1  lookup request this cycle.
- PredIndex  in  INDEX_BITS  lookup index (PC bits).
- PredOutValid  out  1  registered; high one cycle after an accepted lookup.
- PredTaken  out  1  registered; MSB of the looked-up counter.
- PredStrong  out  1  registered; counter is 0 or 2^CTR_WIDTH-1.
- PredHistory  out  max(HIST_BITS,1)  registered; GHR value used for this lookup.
- UpdValid  in  1  outcome update this cycle.
- UpdIndex  in  INDEX_BITS  index of the resolved branch.
- UpdHistory  in  max(HIST_BITS,1)  PredHistory returned with the original prediction.
- UpdTaken  in  1  actual outcome.
- UpdPredTaken  in  1  direction that was predicted.
- MissCount  out  STAT_WIDTH  saturating count of mispredicts.

Behaviour:
- Reset (reset=0, asynchronous):
  - All counters = RESET_CTR; GHR = 0; MissCount = 0.
  - PredOutValid = 0; PredTaken/PredStrong = values decoded from RESET_CTR; PredHistory = 0.
  - Reset asserted mid-operation discards any in-flight lookup and update.
- Effective index:
  - Lookup: PredIndex XOR zero-extended GHR.
  - Update: UpdIndex XOR zero-extended UpdHistory.
  - HIST_BITS=0: effective index = raw index, GHR absent, PredHistory is tied to 0 and UpdHistory is ignored.
- Lookup latency is 1 cycle: PredValid at edge t gives PredOutValid/PredTaken/PredStrong/PredHistory at t+1.
- When PredValid=0, PredOutValid=0 next cycle and the other prediction outputs hold their last values.
- Update on UpdValid, counter at effective update index:
  - UpdTaken=1 and counter < max: +1. At max: holds (saturate).
  - UpdTaken=0 and counter > 0: -1. At 0: holds.
  - UpdValid=0: table unchanged.
- GHR on UpdValid: GHR <= {GHR[HIST_BITS-2:0], UpdTaken}; for HIST_BITS=1, GHR <= UpdTaken.
- Simultaneous lookup and update in the same cycle:
  - The lookup hashes with the pre-shift GHR, and PredHistory reports that pre-shift value.
  - Same effective index: prediction reflects the post-update counter value (write-first bypass).
  - Different indices: independent.
- Decode, counter value c, max M = 2^CTR_WIDTH-1:
  - Taken = c[CTR_WIDTH-1].
  - Strong = (c==0) || (c==M).
  - For CTR_WIDTH=2 this gives 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- MissCount increments on UpdValid && (UpdTaken != UpdPredTaken) and saturates at 2^STAT_WIDTH-1.
- Inputs are sampled on every edge. There is no backpressure: one lookup and one update can be accepted every cycle.

Test Plan:
- Reset then lookup idx 3 → PredOutValid=1 next cycle, PredTaken=0, PredStrong=1, MissCount=0.
- Four taken updates to idx 5 (CTR_WIDTH=2) → counter goes 0→1→2→3→3; lookups after each update give (T,S) = (0,0),(1,0),(1,1),(1,1). Then one not-taken update → (1,0).
- Same cycle: update idx 7 taken (counter 1→2) and lookup idx 7 → PredTaken=1, PredStrong=0 (bypass). Lookup idx 8 in the same cycle is unaffected.
- HIST_BITS=2, INDEX_BITS=4: update outcomes 1,1 → GHR=2'b11. Lookup idx 0 hits entry 3 and PredHistory=2'b11. Update idx 0 with UpdHistory=2'b11 modifies entry 3 only.
- STAT_WIDTH=4: 20 updates with UpdTaken≠UpdPredTaken → MissCount=15. Matched updates leave it unchanged.
- Assert reset mid-stream with PredValid=1 → PredOutValid=0 immediately, all entries read RESET_CTR after release, GHR=0.
